branch_resolve_unit: RTL

Parametrised branch-condition resolver for the ID stage of the MIPS pipeline. Evaluates the full set of conditional-branch compares (signed and unsigned, two-operand and compare-to-zero) on forwarded register operands, registers the decision behind a valid/ready handshake, flags mispredictions against the fetch-stage prediction, and keeps saturating branch statistics. Output feeds the PC-select / flush logic.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond_eval.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - branch condition codes and resolver state encoding
package branch_pkg;

    localparam int BR_OP_W = 3;

    typedef enum logic [BR_OP_W-1:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b010,
        BR_GE  = 3'b011,
        BR_LTU = 3'b100,
        BR_GEU = 3'b101,
        BR_LEZ = 3'b110,
        BR_GTZ = 3'b111
    } br_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluator
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [BR_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic               cond
);

    logic   eq;
    logic   lt_s;
    logic   lt_u;
    logic   rs_zero;
    logic   rs_neg;
    br_op_e op_e;

    // Direct relational compares avoid the overflow hazard of subtract-and-test-sign.
    assign eq      = (rs == rt);
    assign lt_s    = ($signed(rs) < $signed(rt));
    assign lt_u    = (rs < rt);
    assign rs_zero = (rs == '0);
    assign rs_neg  = rs[WIDTH-1];
    assign op_e    = br_op_e'(op);

    always_comb begin
        cond = 1'b0;
        case (op_e)
            BR_EQ:   cond = eq;
            BR_NE:   cond = !eq;
            BR_LT:   cond = lt_s;
            BR_GE:   cond = !lt_s;
            BR_LTU:  cond = lt_u;
            BR_GEU:  cond = !lt_u;
            BR_LEZ:  cond = rs_neg || rs_zero;
            BR_GTZ:  cond = !rs_neg && !rs_zero;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch decision with handshake, flush and statistics
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BR_OP_W-1:0]   in_op,
    input  logic [WIDTH-1:0]     in_rs,
    input  logic [WIDTH-1:0]     in_rt,
    input  logic                 in_pred_taken,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic                 out_mispredict,
    input  logic                 flush,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    br_state_e            state_q, state_d;
    logic                 out_taken_q, out_taken_d;
    logic                 out_mispredict_q, out_mispredict_d;
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic cond;
    logic accept;
    logic handshake;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        if (inc && (v != '1)) begin
            return v + CNT_WIDTH'(1);
        end
        return v;
    endfunction

    branch_cond_eval #(
        .WIDTH (WIDTH)
    ) u_cond_eval (
        .op   (in_op),
        .rs   (in_rs),
        .rt   (in_rt),
        .cond (cond)
    );

    assign out_valid        = (state_q == ST_FULL);
    assign in_ready         = !out_valid || out_ready;
    assign accept           = in_valid && in_ready && !flush;
    assign handshake        = out_valid && out_ready && !flush;
    assign out_taken        = out_taken_q;
    assign out_mispredict   = out_mispredict_q;
    assign branch_count     = branch_count_q;
    assign taken_count      = taken_count_q;
    assign mispredict_count = mispredict_count_q;

    always_comb begin
        state_d          = state_q;
        out_taken_d      = out_taken_q;
        out_mispredict_d = out_mispredict_q;
        // Flush dominates: whatever was held or presented this cycle is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d          = ST_FULL;
            out_taken_d      = cond;
            out_mispredict_d = cond ^ in_pred_taken;
        end else if (handshake) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        taken_count_d      = taken_count_q;
        mispredict_count_d = mispredict_count_q;
        if (clr_stats) begin
            branch_count_d     = '0;
            taken_count_d      = '0;
            mispredict_count_d = '0;
        end else if (handshake) begin
            branch_count_d     = sat_inc(branch_count_q, 1'b1);
            taken_count_d      = sat_inc(taken_count_q, out_taken_q);
            mispredict_count_d = sat_inc(mispredict_count_q, out_mispredict_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_EMPTY;
            out_taken_q        <= 1'b0;
            out_mispredict_q   <= 1'b0;
            branch_count_q     <= '0;
            taken_count_q      <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            out_taken_q        <= out_taken_d;
            out_mispredict_q   <= out_mispredict_d;
            branch_count_q     <= branch_count_d;
            taken_count_q      <= taken_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
